// File: rtl/zxuno_reg_master.sv
// Bus initiator for the ZXUNO two-port register scheme: selects a register through
// IOADDR, then reads or writes it through IODATA, optionally skipping the select.
module zxuno_reg_master #(
    parameter logic [15:0] IOADDR     = 16'hFC3B,
    parameter logic [15:0] IODATA     = 16'hFD3B,
    parameter int          SETUP_CYC  = 1,
    parameter int          STROBE_CYC = 2,
    parameter int          HOLD_CYC   = 1,
    parameter int          ADDR_CACHE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [7:0]  regnum,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [15:0] a_out,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in
);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE
    } state_t;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       we_q;
    logic [7:0] reg_q, wdata_q, cache_q;
    logic       cache_valid;
    logic       cache_hit;
    logic       phase_end;

    assign cache_hit = (ADDR_CACHE != 0) && cache_valid && (cache_q == regnum);
    assign phase_end = (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The counter is reloaded on each phase entry so every phase lasts exactly its parameter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = cache_hit ? D_SETUP : A_SETUP;
                    cnt_next   = SETUP_LD;
                end
            end
            A_SETUP: begin
                if (phase_end) begin
                    state_next = A_STROBE;
                    cnt_next   = STROBE_LD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            A_STROBE: begin
                if (phase_end) begin
                    state_next = A_HOLD;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            A_HOLD: begin
                if (phase_end) begin
                    state_next = D_SETUP;
                    cnt_next   = SETUP_LD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            D_SETUP: begin
                if (phase_end) begin
                    state_next = D_STROBE;
                    cnt_next   = STROBE_LD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            D_STROBE: begin
                if (phase_end) begin
                    state_next = D_HOLD;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            D_HOLD: begin
                if (phase_end) begin
                    state_next = DONE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            reg_q       <= 8'h00;
            wdata_q     <= 8'h00;
            cache_q     <= 8'h00;
            cache_valid <= 1'b0;
            rdata       <= 8'h00;
        end else begin
            if (state == IDLE && req) begin
                we_q    <= we;
                reg_q   <= regnum;
                wdata_q <= wdata;
            end
            if (state == A_HOLD && phase_end) begin
                cache_q     <= reg_q;
                cache_valid <= 1'b1;
            end
            if (state == D_STROBE && phase_end && !we_q) begin
                rdata <= d_in;
            end
        end
    end

    // Outputs are pure state decodes, so address/data only move on phase changes with strobes high.
    always_comb begin
        busy   = (state != IDLE);
        done   = (state == DONE);
        a_out  = 16'h0000;
        d_out  = 8'h00;
        d_oe   = 1'b0;
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        case (state)
            A_SETUP, A_HOLD: begin
                a_out = IOADDR;
                d_out = reg_q;
                d_oe  = 1'b1;
            end
            A_STROBE: begin
                a_out  = IOADDR;
                d_out  = reg_q;
                d_oe   = 1'b1;
                iorq_n = 1'b0;
                wr_n   = 1'b0;
            end
            D_SETUP, D_HOLD: begin
                a_out = IODATA;
                if (we_q) begin
                    d_out = wdata_q;
                    d_oe  = 1'b1;
                end
            end
            D_STROBE: begin
                a_out  = IODATA;
                iorq_n = 1'b0;
                if (we_q) begin
                    d_out = wdata_q;
                    d_oe  = 1'b1;
                    wr_n  = 1'b0;
                end else begin
                    rd_n = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_zxuno_reg_master.sv
// Bench for zxuno_reg_master: three instances (default, no address cache, slow 3/1/2 timing)
// share one randomized stimulus and are compared against a transaction-level timing model.
module tb_zxuno_reg_master;

    localparam int NI = 3;
    localparam int HN = 4096;
    localparam int PS [NI] = '{1, 1, 3};
    localparam int PT [NI] = '{2, 2, 1};
    localparam int PH [NI] = '{1, 1, 2};
    localparam int PC [NI] = '{1, 0, 1};

    typedef struct packed {
        logic [15:0] cyc;
        logic [3:0]  inst;
        logic [15:0] a;
        logic [7:0]  d;
        logic        oe;
        logic        wr_n;
        logic        rd_n;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst, req, we;
    logic [7:0] regnum, wdata, d_in;

    logic        busy   [NI];
    logic        done   [NI];
    logic [7:0]  rdata  [NI];
    logic [15:0] a_out  [NI];
    logic        iorq_n [NI];
    logic        rd_n   [NI];
    logic        wr_n   [NI];
    logic [7:0]  d_out  [NI];
    logic        d_oe   [NI];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int k_last   = 0;
    int model_c  = 0;

    logic       din_fixed_en = 1'b0;
    logic [7:0] din_fixed    = 8'h00;

    logic       rst_h [HN];
    logic       req_h [HN];
    logic       we_h  [HN];
    logic [7:0] rn_h  [HN];
    logic [7:0] wd_h  [HN];
    logic [7:0] din_h [HN];

    logic [15:0] pa [NI];
    logic [7:0]  pd [NI];
    logic        piorq [NI];
    logic        inh [NI];
    int          run [NI];
    int          lowr [NI];
    int          holdr [NI];
    int          busy_cnt [NI];
    int          last_done [NI];
    logic        same_v;

    logic        m_inflight [NI];
    logic        m_miss [NI];
    logic        m_we [NI];
    logic        m_cv [NI];
    logic [7:0]  m_rn [NI];
    logic [7:0]  m_wd [NI];
    logic [7:0]  m_cval [NI];
    logic [7:0]  m_rd [NI];
    int          m_t [NI];
    int          m_free [NI];
    int          m_busy [NI];

    evt_t obs_ev [$];
    evt_t exp_ev [$];
    int   obs_done [$];
    int   exp_done [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    zxuno_reg_master #(.SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1), .ADDR_CACHE(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .regnum(regnum), .wdata(wdata),
        .busy(busy[0]), .done(done[0]), .rdata(rdata[0]), .a_out(a_out[0]),
        .iorq_n(iorq_n[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0]), .d_out(d_out[0]),
        .d_oe(d_oe[0]), .d_in(d_in)
    );

    zxuno_reg_master #(.SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1), .ADDR_CACHE(0)) dut_nocache (
        .clk(clk), .rst(rst), .req(req), .we(we), .regnum(regnum), .wdata(wdata),
        .busy(busy[1]), .done(done[1]), .rdata(rdata[1]), .a_out(a_out[1]),
        .iorq_n(iorq_n[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1]), .d_out(d_out[1]),
        .d_oe(d_oe[1]), .d_in(d_in)
    );

    zxuno_reg_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .ADDR_CACHE(1)) dut_slow (
        .clk(clk), .rst(rst), .req(req), .we(we), .regnum(regnum), .wdata(wdata),
        .busy(busy[2]), .done(done[2]), .rdata(rdata[2]), .a_out(a_out[2]),
        .iorq_n(iorq_n[2]), .rd_n(rd_n[2]), .wr_n(wr_n[2]), .d_out(d_out[2]),
        .d_oe(d_oe[2]), .d_in(d_in)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic evt_t mkEvt(input int c, input int i, input logic [15:0] a,
                                   input logic [7:0] d, input logic oe, input logic w, input logic r);
        evt_t e;
        e.cyc  = 16'(c);
        e.inst = 4'(i);
        e.a    = a;
        e.d    = d;
        e.oe   = oe;
        e.wr_n = w;
        e.rd_n = r;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        d_in = din_fixed_en ? din_fixed : 8'($urandom);
    endtask

    // Protocol monitor plus input history; reset cycles are excluded from all observations.
    always @(negedge clk) begin
        if (cyc < HN) begin
            rst_h[cyc] = rst;
            req_h[cyc] = req;
            we_h[cyc]  = we;
            rn_h[cyc]  = regnum;
            wd_h[cyc]  = wdata;
            din_h[cyc] = d_in;
        end
        for (int i = 0; i < NI; i++) begin
            same_v = (a_out[i] == pa[i]) && (d_out[i] == pd[i]);
            if (rst) begin
                run[i]   = 0;
                lowr[i]  = 0;
                inh[i]   = 1'b0;
                piorq[i] = 1'b1;
            end else begin
                if (busy[i]) busy_cnt[i]++;
                checkOutput("rd_wr_exclusive", 64'(rd_n[i] | wr_n[i]), 64'd1);
                checkOutput("iorq_matches_rw", 64'(iorq_n[i]), 64'(rd_n[i] & wr_n[i]));
                if (done[i]) begin
                    obs_done.push_back(i * 100000 + cyc);
                    last_done[i] = cyc;
                    checkOutput("done_busy", 64'(busy[i]), 64'd1);
                    checkOutput("done_a_out", 64'(a_out[i]), 64'd0);
                    checkOutput("done_d_oe", 64'(d_oe[i]), 64'd0);
                end
                if (!iorq_n[i]) begin
                    if (piorq[i]) begin
                        checkOutput("setup_cycles", 64'(same_v ? run[i] : 0), 64'(PS[i]));
                        obs_ev.push_back(mkEvt(cyc, i, a_out[i], rd_n[i] ? d_out[i] : 8'h00,
                                               d_oe[i], wr_n[i], rd_n[i]));
                        lowr[i] = 1;
                    end else begin
                        checkOutput("strobe_stable", 64'(same_v), 64'd1);
                        lowr[i]++;
                    end
                end else begin
                    if (!piorq[i]) begin
                        checkOutput("strobe_width", 64'(lowr[i]), 64'(PT[i]));
                        inh[i]   = 1'b1;
                        holdr[i] = 0;
                    end
                    if (inh[i]) begin
                        if (same_v) begin
                            holdr[i]++;
                        end else begin
                            checkOutput("hold_cycles", 64'(holdr[i]), 64'(PH[i]));
                            inh[i] = 1'b0;
                        end
                    end
                end
                piorq[i] = iorq_n[i];
            end
            run[i] = same_v ? run[i] + 1 : 1;
            pa[i]  = a_out[i];
            pd[i]  = d_out[i];
        end
    end

    // Reference: each accepted request occupies 1 + (miss ? 2 : 1) * (S+T+H) cycles, with strobe
    // starts, read capture and done derived from the accept cycle by plain arithmetic.
    task automatic modelCycle(input int c);
        for (int i = 0; i < NI; i++) begin
            int per, off;
            per = PS[i] + PT[i] + PH[i];
            if (rst_h[c]) begin
                m_inflight[i] = 1'b0;
                m_cv[i]       = 1'b0;
                m_rd[i]       = 8'h00;
                m_free[i]     = c + 1;
            end else if (m_inflight[i]) begin
                off = m_miss[i] ? per : 0;
                m_busy[i]++;
                if (m_miss[i] && c == m_t[i] + PS[i] + 1)
                    exp_ev.push_back(mkEvt(c, i, 16'hFC3B, m_rn[i], 1'b1, 1'b0, 1'b1));
                if (c == m_t[i] + off + PS[i] + 1)
                    exp_ev.push_back(mkEvt(c, i, 16'hFD3B, m_we[i] ? m_wd[i] : 8'h00,
                                           m_we[i], !m_we[i], m_we[i]));
                if (c == m_t[i] + 1 + off + per) begin
                    exp_done.push_back(i * 100000 + c);
                    if (m_miss[i]) begin
                        m_cv[i]   = 1'b1;
                        m_cval[i] = m_rn[i];
                    end
                    if (!m_we[i]) m_rd[i] = din_h[m_t[i] + off + PS[i] + PT[i]];
                    m_inflight[i] = 1'b0;
                    m_free[i]     = c + 1;
                end
            end else if (c >= m_free[i] && req_h[c]) begin
                m_inflight[i] = 1'b1;
                m_t[i]        = c;
                m_we[i]       = we_h[c];
                m_rn[i]       = rn_h[c];
                m_wd[i]       = wd_h[c];
                m_miss[i]     = !(PC[i] != 0 && m_cv[i] && m_cval[i] == rn_h[c]);
            end
        end
    endtask

    task automatic checkIdle(input int i);
        checkOutput("idle_busy", 64'(busy[i]), 64'd0);
        checkOutput("idle_done", 64'(done[i]), 64'd0);
        checkOutput("idle_a_out", 64'(a_out[i]), 64'd0);
        checkOutput("idle_iorq_n", 64'(iorq_n[i]), 64'd1);
        checkOutput("idle_rd_n", 64'(rd_n[i]), 64'd1);
        checkOutput("idle_wr_n", 64'(wr_n[i]), 64'd1);
        checkOutput("idle_d_out", 64'(d_out[i]), 64'd0);
        checkOutput("idle_d_oe", 64'(d_oe[i]), 64'd0);
    endtask

    task automatic checkWindow();
        for (int c = model_c; c < cyc; c++) modelCycle(c);
        model_c = cyc;
        checkOutput("strobe_event_count", 64'(obs_ev.size()), 64'(exp_ev.size()));
        while (obs_ev.size() > 0 && exp_ev.size() > 0)
            checkOutput("strobe_event", 64'(obs_ev.pop_front()), 64'(exp_ev.pop_front()));
        obs_ev.delete();
        exp_ev.delete();
        checkOutput("done_count", 64'(obs_done.size()), 64'(exp_done.size()));
        while (obs_done.size() > 0 && exp_done.size() > 0)
            checkOutput("done_cycle", 64'(obs_done.pop_front()), 64'(exp_done.pop_front()));
        obs_done.delete();
        exp_done.delete();
        for (int i = 0; i < NI; i++) begin
            checkOutput("busy_cycles", 64'(busy_cnt[i]), 64'(m_busy[i]));
            checkOutput("rdata", 64'(rdata[i]), 64'(m_rd[i]));
            checkIdle(i);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [7:0] r, input logic [7:0] d);
        we     = w;
        regnum = r;
        wdata  = d;
        req    = 1'b1;
        k_last = cyc;
        step();
        req = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n   = 0;
        req = 1'b0;
        do begin
            step();
            n++;
        end while (!(busy[0] == 1'b0 && busy[1] == 1'b0 && busy[2] == 1'b0) && n < 100);
        checkOutput("idle_wait_bound", 64'(n < 100), 64'd1);
        step();
    endtask

    function automatic logic [7:0] pickReg();
        case ($urandom_range(0, 3))
            0:       return 8'h0B;
            1:       return 8'h0C;
            2:       return 8'h5E;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            pa[i] = 16'h0000; pd[i] = 8'h00; piorq[i] = 1'b1; inh[i] = 1'b0;
            run[i] = 0; lowr[i] = 0; holdr[i] = 0; busy_cnt[i] = 0; last_done[i] = 0;
            m_inflight[i] = 1'b0; m_miss[i] = 1'b0; m_we[i] = 1'b0; m_cv[i] = 1'b0;
            m_rn[i] = 8'h00; m_wd[i] = 8'h00; m_cval[i] = 8'h00; m_rd[i] = 8'h00;
            m_t[i] = 0; m_free[i] = 0; m_busy[i] = 0;
        end
        rst = 1'b1; req = 1'b0; we = 1'b0; regnum = 8'h00; wdata = 8'h00; d_in = 8'h00;
        step(); step(); step();
        rst = 1'b0;
        step();
        $display("[TB] reset state");
        checkWindow();

        $display("[TB] cold-cache write 0B <- 5A");
        applyStimulus(1'b1, 8'h0B, 8'h5A);
        waitIdle();
        checkOutput("cold_write_latency_dut", 64'(last_done[0] - k_last), 64'd9);
        checkOutput("cold_write_latency_nocache", 64'(last_done[1] - k_last), 64'd9);
        checkOutput("cold_write_latency_slow", 64'(last_done[2] - k_last), 64'd13);
        checkWindow();

        $display("[TB] cache-hit read of 0B with d_in=C3");
        din_fixed_en = 1'b1;
        din_fixed    = 8'hC3;
        applyStimulus(1'b0, 8'h0B, 8'h00);
        waitIdle();
        din_fixed_en = 1'b0;
        checkOutput("hit_read_latency_dut", 64'(last_done[0] - k_last), 64'd5);
        checkOutput("hit_read_latency_nocache", 64'(last_done[1] - k_last), 64'd9);
        checkOutput("hit_read_latency_slow", 64'(last_done[2] - k_last), 64'd7);
        checkOutput("hit_read_rdata", 64'(rdata[0]), 64'hC3);
        checkWindow();

        $display("[TB] miss on 0C then repeat");
        applyStimulus(1'b1, 8'h0C, 8'($urandom));
        waitIdle();
        checkOutput("miss_0c_latency_dut", 64'(last_done[0] - k_last), 64'd9);
        applyStimulus(1'b0, 8'h0C, 8'h00);
        waitIdle();
        checkOutput("repeat_0c_latency_dut", 64'(last_done[0] - k_last), 64'd5);
        checkOutput("repeat_0c_latency_nocache", 64'(last_done[1] - k_last), 64'd9);
        checkWindow();

        $display("[TB] back-to-back requests");
        req = 1'b1;
        for (int n = 0; n < 60; n++) begin
            we     = 1'($urandom);
            regnum = ($urandom_range(0, 1) == 0) ? 8'h0B : 8'h0C;
            wdata  = 8'($urandom);
            step();
        end
        waitIdle();
        checkWindow();

        $display("[TB] reset during address strobe");
        applyStimulus(1'b1, 8'h5E, 8'($urandom));
        waitIdle();
        checkWindow();
        applyStimulus(1'b1, 8'h77, 8'($urandom));
        step();
        checkOutput("pre_reset_in_strobe", 64'(iorq_n[0]), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            checkOutput("post_reset_iorq_n", 64'(iorq_n[i]), 64'd1);
            checkOutput("post_reset_wr_n", 64'(wr_n[i]), 64'd1);
            checkOutput("post_reset_d_oe", 64'(d_oe[i]), 64'd0);
            checkOutput("post_reset_busy", 64'(busy[i]), 64'd0);
            checkOutput("post_reset_done", 64'(done[i]), 64'd0);
        end
        waitIdle();
        checkWindow();
        applyStimulus(1'b0, 8'h5E, 8'h00);
        waitIdle();
        checkOutput("after_reset_latency_dut", 64'(last_done[0] - k_last), 64'd9);
        checkWindow();
        applyStimulus(1'b1, 8'h77, 8'($urandom));
        waitIdle();
        checkOutput("after_reset_77_latency_dut", 64'(last_done[0] - k_last), 64'd9);
        checkWindow();

        $display("[TB] random transactions");
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'($urandom), pickReg(), 8'($urandom));
            waitIdle();
            checkWindow();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
